// File: rtl/data_byte_ram.sv
// Byte-addressable MEM-stage data memory with combinational little-endian
// word reads and SB/SH/SW writes that wrap modulo the address space.
module data_byte_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  wren,
  input  logic [2:0]            func3,
  output logic [DATA_WIDTH-1:0] DOUT
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [LANES-1:0] be;

  // Lane enables by access size; reserved sizes store nothing.
  always_comb begin
    be = '0;
    unique case (1'b1)
      func3 == 3'b000: be = LANES'(4'b0001);
      func3 == 3'b001: be = LANES'(4'b0011);
      func3 == 3'b010: be = LANES'(4'b1111);
      default:         be = '0;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wren) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) begin
          mem_d[ADDR + ADDR_WIDTH'(k)] = DIN[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_rd
    assign DOUT[8*k +: 8] = mem_q[ADDR + ADDR_WIDTH'(k)];
  end

endmodule

// File: tb/tb_data_byte_ram.sv
// Directed and pseudo-random checks of data_byte_ram against a
// byte-array reference model.
module tb_data_byte_ram;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [7:0]  ADDR = 8'h00;
  logic [31:0] DIN = 32'h0;
  logic        wren = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] DOUT;

  int errors = 0;
  int checks = 0;

  logic [7:0] m [256];

  data_byte_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .ADDR  (ADDR),
    .DIN   (DIN),
    .wren  (wren),
    .func3 (func3),
    .DOUT  (DOUT)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    return {m[8'(a + 8'd3)], m[8'(a + 8'd2)], m[8'(a + 8'd1)], m[a]};
  endfunction

  task automatic model_wr(input logic [2:0] f, input logic [7:0] a,
                          input logic [31:0] d, input logic en);
    int n;
    n = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : (f == 3'b010) ? 4 : 0;
    if (!en) n = 0;
    for (int k = 0; k < n; k++) m[8'(a + 8'(k))] = d[8*k +: 8];
  endtask

  task automatic do_wr(input logic [2:0] f, input logic [7:0] a,
                       input logic [31:0] d, input logic en);
    @(negedge clock);
    func3 = f;
    ADDR  = a;
    DIN   = d;
    wren  = en;
    @(posedge clock);
    #1;
    wren = 1'b0;
    model_wr(f, a, d, en);
  endtask

  task automatic test_reset();
    logic [7:0] addrs [4];
    addrs = '{8'h00, 8'h40, 8'hFC, 8'hFF};
    clear = 1'b1;
    #12;
    clear = 1'b0;
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    #3;
    for (int i = 0; i < 4; i++) begin
      ADDR = addrs[i];
      #1;
      checks++;
      if (DOUT !== 32'h0) begin
        errors++;
        $display("FAIL reset@%h got %h expected %h", addrs[i], DOUT, 32'h0);
      end
    end
  endtask

  task automatic test_word();
    logic [7:0]  a [3];
    logic [31:0] e [3];
    a = '{8'h10, 8'h11, 8'h13};
    e = '{32'hDEADBEEF, 32'h00DEADBE, 32'h000000DE};
    @(negedge clock);
    func3 = 3'b010;
    ADDR  = 8'h10;
    DIN   = 32'hDEADBEEF;
    wren  = 1'b1;
    #1;
    checks++;
    if (DOUT !== 32'h0) begin
      errors++;
      $display("FAIL rdw_old got %h expected %h", DOUT, 32'h0);
    end
    @(posedge clock);
    #1;
    wren = 1'b0;
    model_wr(3'b010, 8'h10, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ADDR = a[i];
      #1;
      checks++;
      if (DOUT !== e[i]) begin
        errors++;
        $display("FAIL sw@%h got %h expected %h", a[i], DOUT, e[i]);
      end
    end
  endtask

  task automatic test_partial();
    do_wr(3'b000, 8'h11, 32'h12345678, 1'b1);
    ADDR = 8'h10;
    #1;
    checks++;
    if (DOUT !== 32'hDEAD78EF) begin
      errors++;
      $display("FAIL sb got %h expected %h", DOUT, 32'hDEAD78EF);
    end
    do_wr(3'b001, 8'h12, 32'hAAAACAFE, 1'b1);
    ADDR = 8'h10;
    #1;
    checks++;
    if (DOUT !== 32'hCAFE78EF) begin
      errors++;
      $display("FAIL sh got %h expected %h", DOUT, 32'hCAFE78EF);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  a [3];
    logic [31:0] e [3];
    a = '{8'hFE, 8'h00, 8'hFF};
    e = '{32'h11223344, 32'h00001122, 32'h22334433};
    // FF,00,01,02 = 33,22,11,00 ; 00..03 = 22,11,00,00
    e[1] = 32'h00001122;
    e[2] = 32'h00112233;
    do_wr(3'b010, 8'hFE, 32'h11223344, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ADDR = a[i];
      #1;
      checks++;
      if (DOUT !== e[i]) begin
        errors++;
        $display("FAIL wrap@%h got %h expected %h", a[i], DOUT, e[i]);
      end
    end
  endtask

  task automatic test_guards();
    logic [7:0] a [4];
    a = '{8'h20, 8'h10, 8'hFE, 8'h00};
    do_wr(3'b011, 8'h20, 32'hFFFFFFFF, 1'b1);
    do_wr(3'b010, 8'h20, 32'h55555555, 1'b0);
    do_wr(3'b111, 8'h20, 32'h77777777, 1'b1);
    ADDR = 8'h20;
    #1;
    checks++;
    if (DOUT !== 32'h0) begin
      errors++;
      $display("FAIL guard got %h expected %h", DOUT, 32'h0);
    end
    @(negedge clock);
    func3 = 3'b010;
    ADDR  = 8'h20;
    DIN   = 32'hA5A5A5A5;
    wren  = 1'b1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    clear = 1'b0;
    wren  = 1'b0;
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ADDR = a[i];
      #1;
      checks++;
      if (DOUT !== 32'h0) begin
        errors++;
        $display("FAIL clr_wr@%h got %h expected %h", a[i], DOUT, 32'h0);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    do_wr(3'b000, 8'hFF, 32'hFFFFFF41, 1'b1);
    ADDR = 8'hFF;
    #1;
    checks++;
    if (DOUT[7:0] !== 8'h41) begin
      errors++;
      $display("FAIL console got %h expected %h", DOUT[7:0], 8'h41);
    end
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      do_wr(f, a, d, 1'($urandom_range(0, 7) != 0));
      ADDR = 8'($urandom_range(0, 255));
      #1;
      exp = model_rd(ADDR);
      checks++;
      if (DOUT !== exp) begin
        errors++;
        $display("FAIL rand%0d@%h got %h expected %h", i, ADDR, DOUT, exp);
      end
      ADDR = 8'hFF;
      #1;
      exp = model_rd(8'hFF);
      checks++;
      if (DOUT !== exp) begin
        errors++;
        $display("FAIL cons%0d got %h expected %h", i, DOUT, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_partial();
    test_wrap();
    test_guards();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
